ro_bank_meter: RTL

//  Bank of NUM_RO NAND-gated ring oscillators, each STAGES gates long (NAND + STAGES-1 INV cells),

---
 rtl/ro_bank_meter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ro_bank_meter.sv
// Bank of NAND-gated ring oscillators with a clocked window/drain/capture controller.
// Single mode returns one RO edge count; pair mode measures A then B and compares them.
`timescale 1ns/1ps
module ro_bank_meter #(
   parameter int  NUM_RO   = 8,
   parameter int  STAGES   = 7,
   parameter int  CNT_W    = 16,
   parameter int  WINDOW   = 1024,
   parameter int  DRAIN    = 4,
   parameter bit  SIM_RING = 1'b0,
   localparam int SEL_W    = $clog2(NUM_RO)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [SEL_W-1:0] ro_sel_a,
   input  logic [SEL_W-1:0] ro_sel_b,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b,
   output logic             resp_bit,
   output logic             tie,
   output logic             sat,
   output logic             sel_err
);
   localparam int SEL_N = 1 << SEL_W;
   localparam int TMAX  = (WINDOW > DRAIN) ? WINDOW : DRAIN;
   localparam int TMR_W = $clog2(TMAX + 1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_CAPTURE, S_DONE} state_t;
   state_t state_reg, state_next;

   logic [TMR_W-1:0] tmr_reg;
   logic             mode_reg, phase_reg;
   logic [SEL_W-1:0] sel_a_reg, sel_b_reg, cur_sel, clr_sel;
   logic [NUM_RO-1:0] ro_en_reg, ro_en_next, clr_reg, clr_next;
   logic [CNT_W-1:0] cnt_all [SEL_N];
   logic [SEL_N-1:0] sel_ok;
   logic [CNT_W-1:0] cap_cnt;
   logic             cap_ok;
   logic [CNT_W-1:0] count_a_reg, count_b_reg;
   logic             resp_reg, tie_reg, sat_reg, sel_err_reg;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:    if (start) state_next = S_CLEAR;
         S_CLEAR:   state_next = S_RUN;
         S_RUN:     if (tmr_reg == '0) state_next = S_DRAIN;
         S_DRAIN:   if (tmr_reg == '0) state_next = S_CAPTURE;
         S_CAPTURE: state_next = (mode_reg && !phase_reg) ? S_CLEAR : S_DONE;
         S_DONE:    state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Enables and clears are registered so the ring and its counter only ever see clean levels.
   always_comb begin
      cur_sel    = phase_reg ? sel_b_reg : sel_a_reg;
      clr_sel    = (state_reg == S_IDLE) ? ro_sel_a : sel_b_reg;
      ro_en_next = '0;
      clr_next   = '0;
      for (int i = 0; i < NUM_RO; i++) begin
         ro_en_next[i] = (state_next == S_RUN)   && (cur_sel == SEL_W'(i));
         clr_next[i]   = (state_next == S_CLEAR) && (clr_sel == SEL_W'(i));
      end
   end

   assign cap_cnt = cnt_all[cur_sel];
   assign cap_ok  = sel_ok[cur_sel];

   always_ff @(posedge clk) begin
      if (rst) begin
         ro_en_reg   <= '0;
         clr_reg     <= '1;
         tmr_reg     <= '0;
         mode_reg    <= 1'b0;
         phase_reg   <= 1'b0;
         sel_a_reg   <= '0;
         sel_b_reg   <= '0;
         count_a_reg <= '0;
         count_b_reg <= '0;
         resp_reg    <= 1'b0;
         tie_reg     <= 1'b0;
         sat_reg     <= 1'b0;
         sel_err_reg <= 1'b0;
      end else begin
         ro_en_reg <= ro_en_next;
         clr_reg   <= clr_next;
         if (state_next != state_reg) begin
            case (state_next)
               S_RUN:   tmr_reg <= TMR_W'(WINDOW - 1);
               S_DRAIN: tmr_reg <= TMR_W'(DRAIN - 1);
               default: tmr_reg <= '0;
            endcase
         end else if (tmr_reg != '0) begin
            tmr_reg <= tmr_reg - TMR_W'(1);
         end
         if (state_reg == S_IDLE && start) begin
            mode_reg    <= mode;
            sel_a_reg   <= ro_sel_a;
            sel_b_reg   <= ro_sel_b;
            phase_reg   <= 1'b0;
            count_a_reg <= '0;
            count_b_reg <= '0;
            resp_reg    <= 1'b0;
            tie_reg     <= 1'b0;
            sat_reg     <= 1'b0;
            sel_err_reg <= 1'b0;
         end
         // The ring has been stopped for DRAIN cycles, so its count is static here.
         if (state_reg == S_CAPTURE) begin
            if (!phase_reg) begin
               count_a_reg <= cap_cnt;
            end else begin
               count_b_reg <= cap_cnt;
               resp_reg    <= count_a_reg > cap_cnt;
               tie_reg     <= count_a_reg == cap_cnt;
            end
            if (cap_cnt == '1) sat_reg     <= 1'b1;
            if (!cap_ok)       sel_err_reg <= 1'b1;
            if (mode_reg && !phase_reg) phase_reg <= 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < SEL_N; gi++) begin : g_ro
      if (gi < NUM_RO) begin : g_live
         logic             ring_out;
         logic             clr_q;
         logic [CNT_W-1:0] cnt_q;

         if (SIM_RING) begin : g_model
            // Cycle-based stand-in: square wave with a half period of (gi % 4) + 1 clk cycles.
            localparam int HALF = (gi % 4) + 1;
            logic [1:0] ph_reg;
            logic       out_reg;
            always_ff @(posedge clk) begin
               if (rst || !ro_en_reg[gi]) begin
                  ph_reg  <= '0;
                  out_reg <= 1'b0;
               end else if (ph_reg == 2'(HALF - 1)) begin
                  ph_reg  <= '0;
                  out_reg <= ~out_reg;
               end else begin
                  ph_reg <= ph_reg + 2'd1;
               end
            end
            assign ring_out = out_reg;
         end else begin : g_ring
            (* keep = "true" *) logic [STAGES-1:0] node;
            assign node[0] = ~(ro_en_reg[gi] & node[STAGES-1]);
            for (genvar si = 1; si < STAGES; si++) begin : g_inv
               assign node[si] = ~node[si-1];
            end
            assign ring_out = node[STAGES-1];
         end

         // Counter lives in the ring's own domain; the clear is a quasi-static level from clk.
         assign clr_q = clr_reg[gi];
         always_ff @(posedge ring_out or posedge clr_q) begin
            if (clr_q)              cnt_q <= '0;
            else if (cnt_q != '1)   cnt_q <= cnt_q + CNT_W'(1);
         end
         assign cnt_all[gi] = cnt_q;
         assign sel_ok[gi]  = 1'b1;
      end else begin : g_pad
         assign cnt_all[gi] = '0;
         assign sel_ok[gi]  = 1'b0;
      end
   end

   assign busy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
   assign done     = (state_reg == S_DONE);
   assign count_a  = count_a_reg;
   assign count_b  = count_b_reg;
   assign resp_bit = resp_reg;
   assign tie      = tie_reg;
   assign sat      = sat_reg;
   assign sel_err  = sel_err_reg;
endmodule
